ghost_ctrl: RTL and testbench
=============================

# ghost_ctrl

Bus-side controller for the ghost sprite source. Holds the CPU-visible shadow copies of sprite origin (x0/y0) and control, commits them atomically at a programmable scan line so the sprite never tears mid-frame, and optionally steps the origin by a signed velocity each frame. It also owns the sprite-RAM write port, unpacking 32-bit CPU words into 16 sequential 2-bit pixel writes. It sits between the MMIO slot interface and one ghost sprite source instance.

## Interface
- ADDR, 10: sprite RAM address width; must match the sprite source.
- COMMIT_Y, 480: scan line on which shadow registers commit (first vblank line).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cs  in  1  slot select
- write  in  1  write strobe (valid with cs)
- read  in  1  read strobe (valid with cs)
- addr  in  5  register offset; only [2:0] decoded
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational on addr
- x, y  in  11 each  current scan coordinates from the frame counter
- x0, y0  out  11 each  committed sprite origin
- ctrl  out  5  committed sprite control
- we  out  1  sprite RAM write enable
- addr_w  out  ADDR  sprite RAM write address
- pixel_in  out  2  sprite RAM write data

## Operation
- Register writes (offset):
  - 0: shadow x0 = wr_data[10:0]; sets dirty.
  - 1: shadow y0 = wr_data[10:0]; sets dirty.
  - 2: shadow ctrl = wr_data[4:0]; sets dirty.
  - 3: velocity: dx = wr_data[3:0] (signed), dy = wr_data[7:4] (signed), move_en = wr_data[8]; takes effect at the next commit.
  - 4: word pointer wptr = wr_data[ADDR-5:0].
  - 5: pixel word; starts a burst.
  - 6: clear overflow.
- Reads:
  - 0: {29'b0, dirty, overflow, busy}.
  - 1: {5'b0, y0, 5'b0, x0} (committed values).
  - Others: 0.
- Commit tick: one cycle, when y == COMMIT_Y && x == 0 && x_d1 != 0. x_d1 is a registered copy of x, reset 0.
- On commit:
  - If dirty: active x0/y0/ctrl load from shadow, and dirty clears.
  - Else if move_en: x0 += sign-extended dx and y0 += sign-extended dy, both mod 2^11 (wrap, no clamp); ctrl is unchanged.
  - Otherwise: no change.
- A shadow write in the same cycle as the commit tick is not committed. The commit uses the pre-write shadow values, and dirty remains set for the next frame.
- Burst FSM, two states:
  - IDLE: a write to offset 5 latches wr_data, goes to WRITE, cnt = 0.
  - WRITE: we = 1, addr_w = {wptr, cnt}, pixel_in = data[2cnt+1:2cnt]. On cnt == 15: wptr += 1 (wraps at 2^(ADDR-4)) and return to IDLE.
- A write to offset 4 or 5 while in WRITE is dropped and sets sticky overflow. Writes to other offsets are always accepted.

## Timing
- Reset values: x0 = y0 = 0, ctrl = 0, shadows = 0, velocity = 0, move_en = 0, dirty = 0, overflow = 0, wptr = 0, FSM = IDLE, we = 0, addr_w = 0, pixel_in = 0.
- Register writes take effect on the clock edge ending the write cycle.
- Commit: active outputs change on the edge ending the commit-tick cycle. Exactly one commit per frame.
- Burst timing:
  - Write to offset 5 in cycle T.
  - we is high in cycles T+1 … T+16, pixel i in cycle T+1+i.
  - busy reads 1 in the same cycles.
  - A new offset-5 write is accepted in cycle T+17 at the earliest.
- we, addr_w and pixel_in are registered. addr_w and pixel_in hold their last values when we = 0.
- Reset asserted mid-burst aborts it: we = 0 next cycle, no further RAM writes.

## Structure
- Shared package ghost_ctrl_pkg holds:
  - register offset constants (REG_X0 … REG_CLR);
  - status bit positions;
  - the burst state typedef enum {IDLE, WRITE}.
- One natural sub-module: sprite_burst_writer. It contains the FSM, cnt, wptr, data latch and RAM port outputs, and exposes start/busy.
- The commit and motion logic stays in ghost_ctrl.

## Test plan
- Reset, then read offsets 0/1 → 0; outputs x0 = y0 = 0, ctrl = 0, we = 0.
- Write x0 = 100, y0 = 50, ctrl = 0x1A mid-frame → outputs unchanged until the commit tick at y = 480, x = 0, then 100/50/0x1A. dirty reads 1 before the commit, 0 after.
- Velocity dx = −3, dy = 2, move_en, x0 = 1 committed:
  - next frames x0 = 2046, 2043 (wrap);
  - y0 increments by 2 per frame;
  - no change when move_en = 0.
- wptr = 63, pixel word 0xE4E4E4E4:
  - 16 we cycles at addr_w 1008 … 1023, pixels 0,1,2,3 repeating;
  - wptr then reads as wrapped to 0 (next burst at addr 0).
- Second offset-5 write at T+5 of a burst → dropped; overflow = 1; only 16 we cycles occur; offset-6 write clears overflow.
- Shadow write of x0 in the exact commit-tick cycle → old shadow committed; new value committed one frame later.

Source files
------------

// File: rtl/ghost_ctrl_pkg.sv
// Shared definitions for the ghost sprite bus controller: register map,
// status bit positions and the sprite-RAM burst state encoding.
package ghost_ctrl_pkg;

  localparam logic [2:0] REG_X0   = 3'd0;
  localparam logic [2:0] REG_Y0   = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_VEL  = 3'd3;
  localparam logic [2:0] REG_WPTR = 3'd4;
  localparam logic [2:0] REG_PIX  = 3'd5;
  localparam logic [2:0] REG_CLR  = 3'd6;

  localparam logic [2:0] RD_STATUS = 3'd0;
  localparam logic [2:0] RD_ORIGIN = 3'd1;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_OVF   = 1;
  localparam int unsigned ST_DIRTY = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } burst_state_t;

  // Sign-extend a 4-bit velocity component to the 11-bit coordinate width.
  function automatic logic [10:0] sext_vel(input logic [3:0] v);
    return {{7{v[3]}}, v};
  endfunction

endpackage

// File: rtl/ghost_ctrl_burst_writer.sv
// Unpacks a 32-bit CPU word into 16 sequential 2-bit sprite-RAM writes at
// {wptr, cnt}, advancing the word pointer after each completed burst.
module sprite_burst_writer
  import ghost_ctrl_pkg::*;
#(
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [31:0]     i_data,
  input  logic            i_wptr_we,
  input  logic [ADDR-5:0] i_wptr,
  output logic            o_busy,
  output logic            o_we,
  output logic [ADDR-1:0] o_addr_w,
  output logic [1:0]      o_pixel_in
);

  burst_state_t    r_state;
  logic [3:0]      r_cnt;
  logic [31:0]     r_data;
  logic [ADDR-5:0] r_wptr;
  logic            r_we;
  logic [ADDR-1:0] r_addr_w;
  logic [1:0]      r_pixel;
  logic [3:0]      w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 4'd1;

  // r_cnt names the pixel currently on the port; the next pixel is preloaded
  // so that we/addr_w/pixel_in are all driven straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_wptr   <= '0;
      r_we     <= 1'b0;
      r_addr_w <= '0;
      r_pixel  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_wptr_we) begin
            r_wptr <= i_wptr;
          end
          if (i_start) begin
            r_data   <= i_data;
            r_cnt    <= '0;
            r_we     <= 1'b1;
            r_addr_w <= {r_wptr, 4'd0};
            r_pixel  <= i_data[1:0];
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (r_cnt == 4'd15) begin
            r_we    <= 1'b0;
            r_wptr  <= r_wptr + 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_addr_w <= {r_wptr, w_cnt_nxt};
            r_pixel  <= r_data[{w_cnt_nxt, 1'b0} +: 2];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == WRITE);
  assign o_we       = r_we;
  assign o_addr_w   = r_addr_w;
  assign o_pixel_in = r_pixel;

endmodule

// File: rtl/ghost_ctrl.sv
// Ghost sprite bus controller: shadow origin/control registers committed once
// per frame at COMMIT_Y, optional per-frame velocity stepping, sprite-RAM writer.
module ghost_ctrl
  import ghost_ctrl_pkg::*;
#(
  parameter int ADDR     = 10,
  parameter int COMMIT_Y = 480
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            write,
  input  logic            read,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  output logic [10:0]     x0,
  output logic [10:0]     y0,
  output logic [4:0]      ctrl,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [1:0]      pixel_in
);

  localparam logic [10:0] LP_COMMIT_Y = 11'(COMMIT_Y);

  logic [10:0] r_sh_x0, r_sh_y0;
  logic [4:0]  r_sh_ctrl;
  logic [3:0]  r_dx, r_dy;
  logic        r_move_en;
  logic        r_dirty, r_ovf;
  logic [10:0] r_x0, r_y0, r_x_d1;
  logic [4:0]  r_ctrl;

  logic [2:0]  w_off;
  logic        w_wr, w_busy, w_tick, w_sh_wr, w_burst_reg, w_drop;
  logic        w_start, w_wptr_we;
  logic        w_unused;

  assign w_off       = addr[2:0];
  assign w_wr        = cs & write;
  assign w_tick      = (y == LP_COMMIT_Y) && (x == '0) && (r_x_d1 != '0);
  assign w_sh_wr     = w_wr && (w_off == REG_X0 || w_off == REG_Y0 || w_off == REG_CTRL);
  assign w_burst_reg = (w_off == REG_WPTR) || (w_off == REG_PIX);
  assign w_drop      = w_wr && w_burst_reg && w_busy;
  assign w_start     = w_wr && (w_off == REG_PIX) && !w_busy;
  assign w_wptr_we   = w_wr && (w_off == REG_WPTR) && !w_busy;
  assign w_unused    = ^{addr[4:3], read};

  // Commit reads the shadows' current (pre-edge) values, so a shadow write in
  // the tick cycle lands after the commit and keeps dirty set for next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_x0   <= '0;
      r_sh_y0   <= '0;
      r_sh_ctrl <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_move_en <= 1'b0;
      r_dirty   <= 1'b0;
      r_ovf     <= 1'b0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_ctrl    <= '0;
      r_x_d1    <= '0;
    end else begin
      r_x_d1 <= x;

      if (w_tick) begin
        if (r_dirty) begin
          r_x0   <= r_sh_x0;
          r_y0   <= r_sh_y0;
          r_ctrl <= r_sh_ctrl;
        end else if (r_move_en) begin
          r_x0 <= r_x0 + sext_vel(r_dx);
          r_y0 <= r_y0 + sext_vel(r_dy);
        end
      end

      if (w_sh_wr) begin
        r_dirty <= 1'b1;
      end else if (w_tick) begin
        r_dirty <= 1'b0;
      end

      if (w_wr) begin
        case (w_off)
          REG_X0:   r_sh_x0   <= wr_data[10:0];
          REG_Y0:   r_sh_y0   <= wr_data[10:0];
          REG_CTRL: r_sh_ctrl <= wr_data[4:0];
          REG_VEL: begin
            r_dx      <= wr_data[3:0];
            r_dy      <= wr_data[7:4];
            r_move_en <= wr_data[8];
          end
          default: ;
        endcase
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && w_off == REG_CLR) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (w_off)
      RD_STATUS: begin
        rd_data[ST_BUSY]  = w_busy;
        rd_data[ST_OVF]   = r_ovf;
        rd_data[ST_DIRTY] = r_dirty;
      end
      RD_ORIGIN: rd_data = {5'b0, r_y0, 5'b0, r_x0};
      default:   rd_data = '0;
    endcase
  end

  sprite_burst_writer #(
    .ADDR(ADDR)
  ) u_burst (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_data     (wr_data),
    .i_wptr_we  (w_wptr_we),
    .i_wptr     (wr_data[ADDR-5:0]),
    .o_busy     (w_busy),
    .o_we       (we),
    .o_addr_w   (addr_w),
    .o_pixel_in (pixel_in)
  );

  assign x0   = r_x0;
  assign y0   = r_y0;
  assign ctrl = r_ctrl;

endmodule

// File: tb/tb_ghost_ctrl.sv
// Directed self-checking bench for ghost_ctrl: register map, frame commit,
// velocity stepping with wrap, sprite-RAM bursts and overflow handling.
module tb_ghost_ctrl;

  logic        clk = 1'b0;
  logic        reset, cs, write, read;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [10:0] x, y, x0, y0;
  logic [4:0]  ctrl;
  logic        we;
  logic [9:0]  addr_w;
  logic [1:0]  pixel_in;

  int n_tests = 0;
  int n_fail  = 0;

  ghost_ctrl #(.ADDR(10), .COMMIT_Y(480)) dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .x(x), .y(y), .x0(x0), .y0(y0), .ctrl(ctrl),
    .we(we), .addr_w(addr_w), .pixel_in(pixel_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = off; wr_data = d;
    cyc();
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] off, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = off;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic commit();
    y = 11'd480; x = 11'd5;
    cyc();
    x = 11'd0;
    cyc();
    x = 11'd1; y = 11'd0;
    cyc();
  endtask

  logic [31:0] r;
  int          we_cnt;

  initial begin
    reset = 1'b1; cs = 0; write = 0; read = 0; addr = '0; wr_data = '0;
    x = '0; y = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    rd(5'd0, r); chk("rst_status", r, 32'h0);
    rd(5'd1, r); chk("rst_origin", r, 32'h0);
    chk("rst_x0", 32'(x0), 32'd0);
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_we", 32'(we), 32'd0);

    // Shadow writes mid-frame, held until the commit tick.
    x = 11'd100; y = 11'd200;
    wr(5'd0, 32'd100);
    wr(5'd1, 32'd50);
    wr(5'd2, 32'h1A);
    chk("pre_x0", 32'(x0), 32'd0);
    rd(5'd0, r); chk("pre_dirty", r, 32'h4);
    y = 11'd480; x = 11'd5; cyc();
    chk("line480_x5_x0", 32'(x0), 32'd0);
    x = 11'd0; cyc();
    chk("commit_x0", 32'(x0), 32'd100);
    chk("commit_y0", 32'(y0), 32'd50);
    chk("commit_ctrl", 32'(ctrl), 32'h1A);
    cyc();
    chk("x0_held_one_tick", 32'(x0), 32'd100);
    x = 11'd1; y = 11'd0; cyc();
    rd(5'd0, r); chk("post_dirty", r, 32'h0);
    rd(5'd1, r); chk("origin_rd", r, 32'h0032_0064);

    // Velocity dx=-3, dy=+2 from x0=1.
    wr(5'd0, 32'd1);
    commit();
    chk("vel_base_x0", 32'(x0), 32'd1);
    wr(5'd3, 32'h12D);
    commit();
    chk("vel_f1_x0", 32'(x0), 32'd2046);
    chk("vel_f1_y0", 32'(y0), 32'd52);
    chk("vel_f1_ctrl", 32'(ctrl), 32'h1A);
    commit();
    chk("vel_f2_x0", 32'(x0), 32'd2043);
    chk("vel_f2_y0", 32'(y0), 32'd54);
    wr(5'd3, 32'h0);
    commit();
    chk("vel_off_x0", 32'(x0), 32'd2043);
    chk("vel_off_y0", 32'(y0), 32'd54);

    // Burst at word 63: addresses 1008..1023, pixels 0,1,2,3 repeating.
    wr(5'd4, 32'd63);
    wr(5'd5, 32'hE4E4_E4E4);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b1_we_%0d", i), 32'(we), 32'd1);
      chk($sformatf("b1_addr_%0d", i), 32'(addr_w), 32'(1008 + i));
      chk($sformatf("b1_pix_%0d", i), 32'(pixel_in), 32'(i % 4));
      rd(5'd0, r); chk($sformatf("b1_busy_%0d", i), r, 32'h1);
      cyc();
    end
    chk("b1_end_we", 32'(we), 32'd0);
    chk("b1_hold_addr", 32'(addr_w), 32'd1023);
    chk("b1_hold_pix", 32'(pixel_in), 32'd3);
    rd(5'd0, r); chk("b1_end_busy", r, 32'h0);

    wr(5'd5, 32'h0000_0001);
    chk("b2_wrap_addr", 32'(addr_w), 32'd0);
    chk("b2_pix0", 32'(pixel_in), 32'd1);
    repeat (16) cyc();
    chk("b2_done_we", 32'(we), 32'd0);

    // Overlapping offset-5 and offset-4 writes during a burst are dropped.
    wr(5'd5, 32'hFFFF_FFFF);
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (we) we_cnt++;
      if (i == 4) begin
        cs = 1; write = 1; addr = 5'd5; wr_data = 32'h0;
      end else if (i == 6) begin
        cs = 1; write = 1; addr = 5'd4; wr_data = 32'd7;
      end else begin
        cs = 0; write = 0; wr_data = '0;
      end
      cyc();
    end
    cs = 0; write = 0;
    chk("ovf_we_cycles", 32'(we_cnt), 32'd16);
    rd(5'd0, r); chk("ovf_set", r, 32'h2);
    wr(5'd6, 32'h0);
    rd(5'd0, r); chk("ovf_clr", r, 32'h0);
    // wptr: 63 -> 0 -> 1 -> 2 after three bursts; the dropped wptr=7 write is ignored.
    wr(5'd5, 32'h0);
    chk("ovf_wptr_kept", 32'(addr_w), 32'd32);
    repeat (16) cyc();

    // Shadow write in the exact commit-tick cycle.
    wr(5'd0, 32'd300);
    y = 11'd480; x = 11'd5; cyc();
    x = 11'd0; cs = 1; write = 1; addr = 5'd0; wr_data = 32'd400;
    cyc();
    cs = 0; write = 0; x = 11'd1; y = 11'd0;
    cyc();
    chk("tick_wr_x0_old", 32'(x0), 32'd300);
    chk("tick_wr_y0", 32'(y0), 32'd50);
    rd(5'd0, r); chk("tick_wr_dirty", r, 32'h4);
    commit();
    chk("tick_wr_x0_new", 32'(x0), 32'd400);
    rd(5'd0, r); chk("tick_wr_dirty_clr", r, 32'h0);

    // Reset mid-burst aborts the RAM writes.
    wr(5'd5, 32'hAAAA_AAAA);
    repeat (3) cyc();
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("rst_abort_we", 32'(we), 32'd0);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (we) we_cnt++;
      cyc();
    end
    chk("rst_abort_no_we", 32'(we_cnt), 32'd0);
    chk("rst_abort_x0", 32'(x0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
